program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL provide parameter START_CYC, default 2: width of each Start pulse in cycles; legal range 1..15.
REQ-002 SHALL provide parameter TIMEOUT, default 16'd60000: maximum CycleCt per program before fault.
REQ-003 SHALL provide port Clk  input  1  rising-edge clock; single clock domain.
REQ-004 SHALL provide port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port Go  input  1  host batch request; level, sampled in IDLE only.
REQ-006 SHALL provide port NumProgs  input  2  batch size minus one (0..3 gives 1..4 programs).
REQ-007 SHALL provide port Ack  input  1  processor halt flag; level, may stay high while halted.
REQ-008 SHALL provide port Start  output  1  processor start/init pulse, registered.
REQ-009 SHALL provide port ProgSel  output  2  index of the current program.
REQ-010 SHALL provide port Busy  output  1  high while a batch is in progress.
REQ-011 SHALL provide port Done  output  1  one-cycle pulse on batch completion.
REQ-012 SHALL provide port Fault  output  1  sticky timeout flag.
REQ-013 SHALL provide port CycleCt  output  16  cycle count of the current or most recent program.
REQ-014 SHALL provide port TotalCt  output  16  cycle count of the whole batch, saturating.

Function
REQ-015 SHALL implement states IDLE, START, ARM and RUN; all outputs SHALL be registered.
REQ-016 IDLE with Go=1: SHALL latch NumProgs into LastIdx, set ProgSel=0, clear Fault, CycleCt and TotalCt, set Busy=1, and enter START.
- All four updates take effect at that same edge.
- In every other state Go SHALL be ignored.
REQ-017 START: Start SHALL be 1 for exactly START_CYC consecutive cycles, then deassert on the edge that enters ARM.
REQ-018 ARM: Start SHALL be 0; SHALL remain in ARM until Ack is sampled 0, then enter RUN.
- A stale Ack=1 held from the previous program SHALL never count as completion.
REQ-019 CycleCt SHALL increment by 1 on every cycle spent in ARM or RUN, and SHALL be cleared on entry to START.
REQ-020 CycleCt SHALL freeze on exit from RUN.
REQ-021 TotalCt SHALL increment by 1 on every cycle with Busy=1, and SHALL saturate at 16'hFFFF without wrapping.
REQ-022 RUN with Ack=1 and ProgSel!=LastIdx: SHALL increment ProgSel and enter START.
REQ-023 RUN with Ack=1 and ProgSel==LastIdx: SHALL enter IDLE, drive Busy=0, and pulse Done=1 for the first IDLE cycle only.
REQ-024 ARM or RUN with CycleCt==TIMEOUT-1 and no completion this cycle: SHALL enter IDLE with Fault=1, Busy=0, Start=0, no Done pulse, and ProgSel holding the failing index.
REQ-025 If Ack completion and the timeout condition occur in the same cycle, completion SHALL take priority and Fault SHALL stay 0.
REQ-026 Go=1 during the Done cycle SHALL be accepted, so the next batch begins START on the following cycle; a held Go therefore runs batches back to back.
REQ-027 Fault SHALL remain 1 until the next accepted Go or reset.
REQ-028 ProgSel SHALL never exceed LastIdx; a NumProgs change mid-batch SHALL have no effect.

Reset
REQ-029 Reset=0 SHALL, asynchronously and regardless of state, force state=IDLE, Start=0, ProgSel=0, Busy=0, Done=0, Fault=0, CycleCt=0, TotalCt=0 and LastIdx=0.
REQ-030 After Reset returns to 1, the block SHALL stay in IDLE until Go is sampled 1 on a rising Clk edge.
REQ-031 Reset asserted mid-RUN SHALL drop Start and Busy immediately, without waiting for a Clk edge.

Verification
REQ-032 Single program: NumProgs=0, Go pulse, Ack held 1 beforehand, then Ack low 2 cycles after Start falls and high 10 cycles later.
- Required: Start high exactly 2 cycles, one Done pulse, ProgSel=0, Fault=0.
- Required: CycleCt equals the ARM+RUN cycle count.
REQ-033 Batch of 3: NumProgs=2, each program acks after 5 RUN cycles.
- Required: ProgSel sequence 0,1,2; three Start pulses.
- Required: Done once, after program 2; TotalCt equals total Busy cycles.
REQ-034 Timeout: TIMEOUT=16'd20, Ack stuck 0.
- Required: Fault=1 and Busy=0 after CycleCt reaches 19; no Done pulse.
- Required: next Go clears Fault.
REQ-035 Same-cycle race: Ack rises on the cycle CycleCt==TIMEOUT-1 -> Done=1 and Fault=0.
REQ-036 Reset=0 mid-RUN of program 1 -> all outputs zero asynchronously; a Go after release restarts at ProgSel=0.
REQ-037 Go held high continuously, NumProgs=1 -> second batch Start asserts the cycle after Done; Go ignored while Busy=1.

Source files
------------

// File: rtl/program_sequencer.sv
// Batch program sequencer: starts up to four processor programs in turn, waits
// for each halt acknowledge, and tracks per-program and per-batch cycle counts.
module program_sequencer #(
  parameter int unsigned START_CYC = 2,
  parameter logic [15:0] TIMEOUT   = 16'd60000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Go,
  input  logic [1:0]  NumProgs,
  input  logic        Ack,
  output logic        Start,
  output logic [1:0]  ProgSel,
  output logic        Busy,
  output logic        Done,
  output logic        Fault,
  output logic [15:0] CycleCt,
  output logic [15:0] TotalCt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] ARM   = 2'd2;
  localparam logic [1:0] RUN   = 2'd3;

  localparam logic [3:0]  START_LAST   = 4'(START_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  logic [1:0]  state;
  logic [3:0]  startCnt;
  logic [1:0]  lastIdx;

  logic [1:0]  stateNxt;
  logic [3:0]  startCntNxt;
  logic [1:0]  lastIdxNxt;
  logic        startNxt;
  logic [1:0]  progSelNxt;
  logic        busyNxt;
  logic        doneNxt;
  logic        faultNxt;
  logic [15:0] cycleCtNxt;
  logic [15:0] totalCtNxt;
  logic        timeoutHit;

  assign timeoutHit = (CycleCt == TIMEOUT_LAST);

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    stateNxt    = state;
    startCntNxt = startCnt;
    lastIdxNxt  = lastIdx;
    startNxt    = Start;
    progSelNxt  = ProgSel;
    busyNxt     = Busy;
    doneNxt     = 1'b0;
    faultNxt    = Fault;
    cycleCtNxt  = CycleCt;
    if (Busy) begin
      totalCtNxt = satInc(TotalCt);
    end else begin
      totalCtNxt = TotalCt;
    end

    case (state)
      IDLE: begin
        if (Go) begin
          stateNxt    = START;
          startCntNxt = 4'd0;
          lastIdxNxt  = NumProgs;
          startNxt    = 1'b1;
          progSelNxt  = 2'd0;
          busyNxt     = 1'b1;
          faultNxt    = 1'b0;
          cycleCtNxt  = 16'd0;
          totalCtNxt  = 16'd0;
        end else begin
          stateNxt = IDLE;
        end
      end

      START: begin
        if (startCnt == START_LAST) begin
          stateNxt = ARM;
          startNxt = 1'b0;
        end else begin
          startCntNxt = startCnt + 4'd1;
        end
      end

      // Wait for Ack to drop so a halt flag left over from the previous program is not taken as done.
      ARM: begin
        cycleCtNxt = CycleCt + 16'd1;
        if (timeoutHit) begin
          stateNxt = IDLE;
          busyNxt  = 1'b0;
          faultNxt = 1'b1;
          startNxt = 1'b0;
        end else if (!Ack) begin
          stateNxt = RUN;
        end else begin
          stateNxt = ARM;
        end
      end

      // Completion is checked before the timeout so a same-cycle race ends cleanly.
      RUN: begin
        cycleCtNxt = CycleCt + 16'd1;
        if (Ack) begin
          if (ProgSel == lastIdx) begin
            stateNxt = IDLE;
            busyNxt  = 1'b0;
            doneNxt  = 1'b1;
          end else begin
            stateNxt    = START;
            progSelNxt  = ProgSel + 2'd1;
            startNxt    = 1'b1;
            startCntNxt = 4'd0;
            cycleCtNxt  = 16'd0;
          end
        end else if (timeoutHit) begin
          stateNxt = IDLE;
          busyNxt  = 1'b0;
          faultNxt = 1'b1;
          startNxt = 1'b0;
        end else begin
          stateNxt = RUN;
        end
      end

      default: begin
        stateNxt = IDLE;
        startNxt = 1'b0;
        busyNxt  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      startCnt <= 4'd0;
      lastIdx  <= 2'd0;
      Start    <= 1'b0;
      ProgSel  <= 2'd0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Fault    <= 1'b0;
      CycleCt  <= 16'd0;
      TotalCt  <= 16'd0;
    end else begin
      state    <= stateNxt;
      startCnt <= startCntNxt;
      lastIdx  <= lastIdxNxt;
      Start    <= startNxt;
      ProgSel  <= progSelNxt;
      Busy     <= busyNxt;
      Done     <= doneNxt;
      Fault    <= faultNxt;
      CycleCt  <= cycleCtNxt;
      TotalCt  <= totalCtNxt;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: stimulus queues the expected batch
// result, a negedge monitor scores each batch end and every Start pulse.
module tb_program_sequencer;

  localparam int START_CYC = 2;

  logic        Clk;
  logic        Reset;
  logic        Go;
  logic [1:0]  NumProgs;
  logic        Ack;
  logic        Start;
  logic [1:0]  ProgSel;
  logic        Busy;
  logic        Done;
  logic        Fault;
  logic [15:0] CycleCt;
  logic [15:0] TotalCt;

  program_sequencer #(.START_CYC(START_CYC), .TIMEOUT(16'd20)) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go), .NumProgs(NumProgs), .Ack(Ack),
    .Start(Start), .ProgSel(ProgSel), .Busy(Busy), .Done(Done), .Fault(Fault),
    .CycleCt(CycleCt), .TotalCt(TotalCt)
  );

  typedef struct {
    logic        done;
    logic        fault;
    logic [1:0]  sel;
    logic [15:0] cyc;
    logic [15:0] tot;
    int          starts;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   startsSeen = 0;
  int   widthSeen = 0;
  logic prevBusy = 1'b0;
  logic prevStart = 1'b0;
  logic prevDone = 1'b0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expectBatch(input logic d, input logic f, input logic [1:0] s,
                             input logic [15:0] c, input logic [15:0] t, input int n);
    exp_t x;
    x.done = d; x.fault = f; x.sel = s; x.cyc = c; x.tot = t; x.starts = n;
    sb.push_back(x);
  endtask

  task automatic startBatch(input logic [1:0] np);
    NumProgs = np;
    Go = 1'b1;
    tick();
    Go = 1'b0;
  endtask

  // One program, entered just after the edge into START, with Ack high (stale) on entry.
  task automatic runProg(input int armExtra, input int runLow);
    repeat (START_CYC) tick();
    repeat (armExtra) tick();
    Ack = 1'b0;
    repeat (runLow) tick();
    Ack = 1'b1;
    tick();
  endtask

  // Monitor: scores Start pulses and each batch end against the scoreboard.
  initial begin
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        prevBusy = 1'b0; prevStart = 1'b0; prevDone = 1'b0;
      end else begin
        if (Busy && !prevBusy) begin
          startsSeen = 0;
          chk("fault_clear_on_go", 32'(Fault), 32'd0);
        end
        if (Start && !prevStart) begin
          chk("progsel_at_start", 32'(ProgSel), 32'(startsSeen));
          startsSeen++;
          widthSeen = 0;
        end
        if (Start) widthSeen++;
        if (!Start && prevStart) chk("start_width", 32'(widthSeen), 32'(START_CYC));
        if (prevDone) chk("done_single_cycle", 32'(Done), 32'd0);
        if (!Busy && prevBusy) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_batch_end: got batch end, want none (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk("batch_done", 32'(Done), 32'(e.done));
            chk("batch_fault", 32'(Fault), 32'(e.fault));
            chk("batch_progsel", 32'(ProgSel), 32'(e.sel));
            chk("batch_cyclect", 32'(CycleCt), 32'(e.cyc));
            chk("batch_totalct", 32'(TotalCt), 32'(e.tot));
            chk("batch_starts", 32'(startsSeen), 32'(e.starts));
          end
        end
        prevBusy = Busy; prevStart = Start; prevDone = Done;
      end
    end
  end

  initial begin
    Reset = 1'b0; Go = 1'b0; NumProgs = 2'd0; Ack = 1'b1;
    #3;
    chk("rst_start", 32'(Start), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_totalct", 32'(TotalCt), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (3) tick();
    chk("idle_without_go", 32'(Busy), 32'd0);

    // Single program: 2 stale-Ack ARM cycles, 10 Ack-low cycles, completion edge.
    expectBatch(1'b1, 1'b0, 2'd0, 16'd13, 16'd15, 1);
    startBatch(2'd0);
    runProg(2, 10);
    repeat (2) tick();

    // Batch of three, each program 1 ARM + 5 low + completion = 7 cycles.
    expectBatch(1'b1, 1'b0, 2'd2, 16'd7, 16'd27, 3);
    startBatch(2'd2);
    runProg(1, 5);
    runProg(1, 5);
    runProg(1, 5);
    repeat (2) tick();

    // Timeout on program 1 of two: Ack stuck low for 20 ARM/RUN cycles.
    expectBatch(1'b0, 1'b1, 2'd1, 16'd20, 16'd28, 2);
    startBatch(2'd1);
    runProg(0, 3);
    repeat (START_CYC) tick();
    Ack = 1'b0;
    repeat (20) tick();
    repeat (3) tick();
    chk("fault_sticky", 32'(Fault), 32'd1);
    chk("fault_busy_low", 32'(Busy), 32'd0);
    chk("fault_start_low", 32'(Start), 32'd0);
    Ack = 1'b1;
    tick();

    // Race: Ack rises on the cycle CycleCt == TIMEOUT-1; completion must win.
    expectBatch(1'b1, 1'b0, 2'd0, 16'd20, 16'd22, 1);
    startBatch(2'd0);
    chk("go_clears_fault", 32'(Fault), 32'd0);
    runProg(2, 17);
    repeat (2) tick();

    // Reset mid-RUN of program 1, then a fresh batch restarts at ProgSel 0.
    startBatch(2'd2);
    runProg(0, 3);
    repeat (START_CYC) tick();
    Ack = 1'b0;
    repeat (3) tick();
    #1 Reset = 1'b0;
    #1;
    chk("async_rst_busy", 32'(Busy), 32'd0);
    chk("async_rst_start", 32'(Start), 32'd0);
    chk("async_rst_progsel", 32'(ProgSel), 32'd0);
    chk("async_rst_cyclect", 32'(CycleCt), 32'd0);
    chk("async_rst_totalct", 32'(TotalCt), 32'd0);
    chk("async_rst_fault", 32'(Fault), 32'd0);
    chk("async_rst_done", 32'(Done), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    Ack = 1'b1;
    tick();
    expectBatch(1'b1, 1'b0, 2'd0, 16'd4, 16'd6, 1);
    startBatch(2'd0);
    runProg(1, 2);
    repeat (2) tick();

    // Go held high: NumProgs change mid-batch ignored, next batch starts right after Done.
    expectBatch(1'b1, 1'b0, 2'd1, 16'd3, 16'd10, 2);
    expectBatch(1'b1, 1'b0, 2'd3, 16'd2, 16'd16, 4);
    NumProgs = 2'd1;
    Go = 1'b1;
    tick();
    NumProgs = 2'd3;
    runProg(0, 2);
    runProg(0, 2);
    chk("b2b_done", 32'(Done), 32'd1);
    tick();
    chk("b2b_start", 32'(Start), 32'd1);
    chk("b2b_busy", 32'(Busy), 32'd1);
    chk("b2b_progsel", 32'(ProgSel), 32'd0);
    runProg(0, 1);
    Go = 1'b0;
    runProg(0, 1);
    runProg(0, 1);
    runProg(0, 1);
    repeat (4) tick();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
